step_phase_decoder: RTL
=======================

# step_phase_decoder

Receive-side monitor for the elevator stepper drive. It watches the 4-bit coil phase pattern that drives the motor GPIO and decodes each full step into direction and a signed step. From that it keeps the car position in steps, the current floor index, and an at-floor flag. Illegal phase sequences and overtravel raise a sticky fault. The block sits beside the stepper controller, and its outputs feed the stop logic and the HEX floor display.

## Interface
Parameters:
- STEPS_PER_FLOOR, 200: full steps between adjacent floors (≥2).
- NUM_FLOORS, 4: number of floors; floor 0 is the home position.
- POS_W, 16: position width; must hold (NUM_FLOORS-1)*STEPS_PER_FLOOR.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level).
- Clear_b  in  1  reset, asynchronous, active-low.
- phase  in  4  coil pattern. Legal values are one-hot wave drive (0001→0010→0100→1000 = up) or 0000 (coils off). May be asynchronous to clock.
- home  in  1  home limit sensor, level-high while the car is at floor 0. Asynchronous.
- fault_clr  in  1  synchronous, 1-cycle pulse; clears a fault.
- position  out  POS_W  step count above home.
- floor  out  2  current floor index = position / STEPS_PER_FLOOR.
- at_floor  out  1  high when calibrated, not faulted, and position is an exact multiple of STEPS_PER_FLOOR.
- dir  out  1  direction of the last accepted step (1 = up).
- step_pulse  out  1  one-cycle strobe per accepted step.
- calibrated  out  1  high while in TRACK.
- fault  out  1  high while in FAULT.

## Operation
- `phase` and `home` each pass through a 2-flop synchronizer. `last_ph` holds the last nonzero synchronized phase; its reset value is 0001.
- A **step event** occurs when the synchronized phase is nonzero and differs from `last_ph`:
  - Up step: new phase = rotate-left(`last_ph`).
  - Down step: new phase = rotate-right(`last_ph`).
  - Anything else is illegal: a two-step jump, or a multi-hot pattern such as 0011 or 1111.
- Synchronized phase 0000 is ignored; `last_ph` is retained.
- States:
  - UNCAL (reset state):
    - `position`/`floor` held at 0.
    - Step events update `last_ph` only; no fault checking.
    - Synchronized `home` = 1 → TRACK, with position 0.
  - TRACK:
    - Up step: position+1, dir=1, step_pulse.
    - Down step: position−1, dir=0, step_pulse.
    - Illegal pattern → FAULT.
    - Down step at position 0 → FAULT (underflow).
    - Up step at position (NUM_FLOORS-1)*STEPS_PER_FLOOR → FAULT (overtravel).
    - Synchronized `home` = 1 re-zeros position, floor and the sub-counter. This is not a fault.
  - FAULT:
    - position, floor and dir frozen; at_floor = 0; step events ignored except that `last_ph` is still updated.
    - `fault_clr` → UNCAL, with position, floor and sub-counter cleared.
- Floor is derived without a divider. A sub-counter `in_floor` runs 0..STEPS_PER_FLOOR-1 alongside position:
  - Up wrap (`in_floor` = STEPS_PER_FLOOR-1 → 0): floor+1.
  - Down wrap (`in_floor` = 0 → STEPS_PER_FLOOR-1): floor−1.
- Simultaneous events:
  - `home` and a step event in the same cycle in TRACK: home wins. Position becomes 0, `last_ph` takes the new phase, step_pulse still fires, dir updates.
  - A fault-causing step in the cycle `fault_clr` arrives: the block is in TRACK or UNCAL, where `fault_clr` has no effect, so FAULT is entered.
- Reset values: position 0, floor 0, at_floor 0, dir 0, step_pulse 0, calibrated 0, fault 0, state UNCAL.
- Reset mid-operation immediately returns all outputs to these values. Calibration is lost and requires `home` again.

## Timing
- A phase change meeting setup before edge k is reflected on edge k+2 (2 sync stages plus 1 decode register). At edge k+2:
  - position, floor, dir and state update;
  - step_pulse is high for exactly the one cycle following edge k+2.
- at_floor is registered and updates on the same edge as position.
- `home` uses the same 2-cycle sync latency. calibrated rises on edge k+2 after `home` rises before edge k.
- fault rises on the same edge as the offending step would have been accepted.
- `fault_clr` sampled on edge j: fault = 0 after edge j.
- Minimum phase dwell is 3 clock cycles. Shorter dwells may be missed, and that is not checked.

## Structure
- Package `elevator_pkg`:
  - state encoding (UNCAL, TRACK, FAULT);
  - phase constants PH_A=0001, PH_B=0010, PH_C=0100, PH_D=1000, PH_OFF=0000;
  - rotate-left/right helper functions, shared with the stepper controller.
- Sub-module `sync2` (parameterized width, 2-flop synchronizer, async active-low reset to 0). Instantiated once for {home, phase}.
- Everything else stays in one module: decode, FSM, position, sub-counter, floor.

## Test plan
- Reset, then home=1, then 5 up steps (0001→0010→0100→1000→0001→0010), each held 10 cycles → calibrated=1, position=5, dir=1, exactly 5 step_pulses, at_floor=0.
- STEPS_PER_FLOOR=4, calibrated at 0, 4 up steps then 1 down step → after 4 steps floor=1, at_floor=1; after the down step position=3, floor=0, at_floor=0.
- Calibrated at position 2, phase jumps 0001→0100 → fault=1, position stays 2, no step_pulse. Then fault_clr pulse → fault=0, calibrated=0, position=0.
- Calibrated at 0, one down step → fault=1. NUM_FLOORS=2, STEPS_PER_FLOOR=4, position 4, one up step → fault=1.
- Steps issued while uncalibrated → position stays 0, no step_pulse. Home asserted at position 3 in the same cycle as a step → position=0, step_pulse=1.
- Phase 0000 inserted between 0010 and 0100, and Clear_b pulsed low mid-sequence → 0000 gives no step and no fault; Clear_b gives all outputs 0 asynchronously and state UNCAL.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator stepper definitions: decoder states, coil phase constants
// and phase rotation helpers used by both the controller and the monitor.
package elevator_pkg;

   localparam int unsigned PH_W = 4;

   typedef enum logic [1:0] {
      ST_UNCAL = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

   localparam logic [PH_W-1:0] PH_A   = 4'b0001;
   localparam logic [PH_W-1:0] PH_B   = 4'b0010;
   localparam logic [PH_W-1:0] PH_C   = 4'b0100;
   localparam logic [PH_W-1:0] PH_D   = 4'b1000;
   localparam logic [PH_W-1:0] PH_OFF = 4'b0000;

   // One decoded phase transition
   typedef struct packed {
      logic evt;
      logic up;
      logic dn;
      logic bad;
   } step_dec_t;

   function automatic logic [PH_W-1:0] ph_rotl(input logic [PH_W-1:0] p);
      return {p[PH_W-2:0], p[PH_W-1]};
   endfunction

   function automatic logic [PH_W-1:0] ph_rotr(input logic [PH_W-1:0] p);
      return {p[0], p[PH_W-1:1]};
   endfunction

   function automatic logic ph_onehot(input logic [PH_W-1:0] p);
      return (p != PH_OFF) && ((p & (p - PH_W'(1))) == PH_OFF);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, cleared to zero on reset.
module sync2 #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/step_phase_decoder.sv
// Stepper coil phase monitor: decodes full steps, tracks car position, floor
// and at-floor status, and latches a fault on illegal sequences or overtravel.
module step_phase_decoder
   import elevator_pkg::*;
#(
   parameter int unsigned STEPS_PER_FLOOR = 200,
   parameter int unsigned NUM_FLOORS      = 4,
   parameter int unsigned POS_W           = 16
) (
   input  logic             clock,
   input  logic             Clear_b,
   input  logic [PH_W-1:0]  phase,
   input  logic             home,
   input  logic             fault_clr,
   output logic [POS_W-1:0] position,
   output logic [1:0]       floor,
   output logic             at_floor,
   output logic             dir,
   output logic             step_pulse,
   output logic             calibrated,
   output logic             fault
);

   localparam int unsigned FLR_W = 2;
   localparam int unsigned IF_W  = (STEPS_PER_FLOOR > 1) ? $clog2(STEPS_PER_FLOOR) : 1;
   localparam logic [POS_W-1:0] POS_MAX = POS_W'((NUM_FLOORS - 1) * STEPS_PER_FLOOR);
   localparam logic [IF_W-1:0]  IF_MAX  = IF_W'(STEPS_PER_FLOOR - 1);

   logic [PH_W:0]    sync_out;
   logic [PH_W-1:0]  ph_s;
   logic             home_s;
   step_dec_t        dec;

   state_e           state_q, state_d;
   logic [PH_W-1:0]  last_ph_q, last_ph_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [IF_W-1:0]  in_floor_q, in_floor_d;
   logic [FLR_W-1:0] floor_q, floor_d;
   logic             dir_q, dir_d;
   logic             pulse_q, pulse_d;
   logic             at_floor_q, at_floor_d;
   logic             calibrated_q, calibrated_d;
   logic             fault_q, fault_d;

   sync2 #(.W(PH_W + 1)) u_sync (
      .clk   (clock),
      .rst_n (Clear_b),
      .d     ({home, phase}),
      .q     (sync_out)
   );

   assign home_s = sync_out[PH_W];
   assign ph_s   = sync_out[PH_W-1:0];

   // Classify the synchronized phase against the last nonzero pattern
   always_comb begin
      dec     = '0;
      dec.evt = (ph_s != PH_OFF) && (ph_s != last_ph_q);
      dec.up  = dec.evt && ph_onehot(ph_s) && (ph_s == ph_rotl(last_ph_q));
      dec.dn  = dec.evt && ph_onehot(ph_s) && (ph_s == ph_rotr(last_ph_q));
      dec.bad = dec.evt && !dec.up && !dec.dn;
   end

   // Next-state, position and floor tracking
   always_comb begin
      state_d    = state_q;
      last_ph_d  = dec.evt ? ph_s : last_ph_q;
      pos_d      = pos_q;
      in_floor_d = in_floor_q;
      floor_d    = floor_q;
      dir_d      = dir_q;
      pulse_d    = 1'b0;

      case (state_q)
         ST_UNCAL: begin
            pos_d      = '0;
            in_floor_d = '0;
            floor_d    = '0;
            if (home_s) state_d = ST_TRACK;
         end
         ST_TRACK: begin
            if (dec.bad) begin
               state_d = ST_FAULT;
            end else if (home_s) begin
               // Home sensor re-zeros even when a step lands in the same cycle
               pos_d      = '0;
               in_floor_d = '0;
               floor_d    = '0;
               if (dec.up || dec.dn) begin
                  pulse_d = 1'b1;
                  dir_d   = dec.up;
               end
            end else if (dec.up) begin
               if (pos_q == POS_MAX) begin
                  state_d = ST_FAULT;
               end else begin
                  pos_d   = pos_q + POS_W'(1);
                  pulse_d = 1'b1;
                  dir_d   = 1'b1;
                  if (in_floor_q == IF_MAX) begin
                     in_floor_d = '0;
                     floor_d    = floor_q + FLR_W'(1);
                  end else begin
                     in_floor_d = in_floor_q + IF_W'(1);
                  end
               end
            end else if (dec.dn) begin
               if (pos_q == '0) begin
                  state_d = ST_FAULT;
               end else begin
                  pos_d   = pos_q - POS_W'(1);
                  pulse_d = 1'b1;
                  dir_d   = 1'b0;
                  if (in_floor_q == '0) begin
                     in_floor_d = IF_MAX;
                     floor_d    = floor_q - FLR_W'(1);
                  end else begin
                     in_floor_d = in_floor_q - IF_W'(1);
                  end
               end
            end
         end
         ST_FAULT: begin
            if (fault_clr) begin
               state_d    = ST_UNCAL;
               pos_d      = '0;
               in_floor_d = '0;
               floor_d    = '0;
            end
         end
         default: begin
            state_d = ST_UNCAL;
         end
      endcase

      calibrated_d = (state_d == ST_TRACK);
      fault_d      = (state_d == ST_FAULT);
      at_floor_d   = calibrated_d && (in_floor_d == '0);
   end

   always_ff @(posedge clock or negedge Clear_b) begin
      if (!Clear_b) begin
         state_q      <= ST_UNCAL;
         last_ph_q    <= PH_A;
         pos_q        <= '0;
         in_floor_q   <= '0;
         floor_q      <= '0;
         dir_q        <= 1'b0;
         pulse_q      <= 1'b0;
         at_floor_q   <= 1'b0;
         calibrated_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_ph_q    <= last_ph_d;
         pos_q        <= pos_d;
         in_floor_q   <= in_floor_d;
         floor_q      <= floor_d;
         dir_q        <= dir_d;
         pulse_q      <= pulse_d;
         at_floor_q   <= at_floor_d;
         calibrated_q <= calibrated_d;
         fault_q      <= fault_d;
      end
   end

   assign position   = pos_q;
   assign floor      = floor_q;
   assign at_floor   = at_floor_q;
   assign dir        = dir_q;
   assign step_pulse = pulse_q;
   assign calibrated = calibrated_q;
   assign fault      = fault_q;

endmodule
